// File: rtl/processor_param.sv
// processor_param: parametrised multi-cycle accumulator processor with a hardware return stack,
// a host program-load port, run/step execution control and a sticky stack-fault flag.
// Latency: 4 cycles per instruction (FETCH/DECODE/EXECUTE/WRITEBACK); LD/ST take 5 via MEMORY.
// Backpressure: none; run/step gate instruction starts, prog_we is accepted only in IDLE or HALT.
//
// Ports:
//   clk, reset             : sole clock, synchronous active-high reset
//   run, step              : free-run level / single-instruction pulse (honoured from IDLE)
//   prog_we/addr/data      : program memory write port, instruction word = {opcode, operand}
//   data_output            : accumulator
//   current_state_output   : FSM state code (IDLE=0 .. HALT=6)
//   pc_output              : program counter
//   opcode/operand_bus_out : fields latched in DECODE
//   halted, fault          : in HALT state / sticky stack overflow-underflow
module processor_param #(
   parameter int DATA_WIDTH      = 16,
   parameter int PROG_ADDR_WIDTH = 8,
   parameter int DMEM_ADDR_WIDTH = 4,
   parameter int STACK_DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       run,
   input  logic                       step,
   input  logic                       prog_we,
   input  logic [PROG_ADDR_WIDTH-1:0] prog_addr,
   input  logic [2*DATA_WIDTH-1:0]    prog_data,
   output logic [DATA_WIDTH-1:0]      data_output,
   output logic [2:0]                 current_state_output,
   output logic [PROG_ADDR_WIDTH-1:0] pc_output,
   output logic [DATA_WIDTH-1:0]      opcode_bus_output,
   output logic [DATA_WIDTH-1:0]      operand_bus_output,
   output logic                       halted,
   output logic                       fault
);

   localparam int DW    = DATA_WIDTH;
   localparam int PAW   = PROG_ADDR_WIDTH;
   localparam int DAW   = DMEM_ADDR_WIDTH;
   // Stack pointer counts 0..STACK_DEPTH, so it needs one more code than the entry count.
   localparam int SPW   = $clog2(STACK_DEPTH + 1);
   localparam int SLOTS = 1 << SPW;

   localparam logic [PAW-1:0] PC_ONE  = PAW'(1);
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_SUBI = 4'h3;
   localparam logic [3:0] OP_LD   = 4'h4;
   localparam logic [3:0] OP_ST   = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_JZ   = 4'h7;
   localparam logic [3:0] OP_CALL = 4'h8;
   localparam logic [3:0] OP_RET  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALT      = 3'd6
   } state_t;

   state_t           r_state;
   logic [PAW-1:0]   r_pc;
   logic [PAW-1:0]   r_npc;        // next pc computed in EXECUTE, committed in WRITEBACK
   logic [DW-1:0]    r_acc;
   logic [DW-1:0]    r_res;        // next acc computed in EXECUTE/MEMORY, committed in WRITEBACK
   logic [2*DW-1:0]  r_instr;
   logic [DW-1:0]    r_opcode;
   logic [DW-1:0]    r_operand;
   logic [SPW-1:0]   r_sp;
   logic             r_halted;
   logic             r_fault;

   logic [2*DW-1:0]  r_pmem  [0:(1<<PAW)-1];
   logic [DW-1:0]    r_dmem  [0:(1<<DAW)-1];
   logic [PAW-1:0]   r_stack [0:SLOTS-1];

   logic [3:0]       w_op;
   logic [PAW-1:0]   w_target;
   logic [PAW-1:0]   w_pc_inc;
   logic [DAW-1:0]   w_daddr;
   logic [SPW-1:0]   w_sp_dec;
   logic             w_stack_full;
   logic             w_stack_empty;
   logic             w_pmem_we;
   logic             w_dmem_we;

   assign w_op          = r_opcode[3:0];
   assign w_target      = r_operand[PAW-1:0];
   assign w_pc_inc      = r_pc + PC_ONE;
   assign w_daddr       = r_operand[DAW-1:0];
   assign w_sp_dec      = r_sp - SP_ONE;
   assign w_stack_full  = (r_sp == SP_FULL);
   assign w_stack_empty = (r_sp == '0);

   // Program loads are independent of reset so a host can reload while holding the core in reset.
   assign w_pmem_we = prog_we && ((r_state == S_IDLE) || (r_state == S_HALT));
   // A store interrupted by reset in MEMORY must not land.
   assign w_dmem_we = !reset && (r_state == S_MEMORY) && (w_op == OP_ST);

   always_ff @(posedge clk) begin
      if (w_pmem_we) r_pmem[prog_addr] <= prog_data;
      if (w_dmem_we) r_dmem[w_daddr]   <= r_acc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_npc     <= '0;
         r_acc     <= '0;
         r_res     <= '0;
         r_instr   <= '0;
         r_opcode  <= '0;
         r_operand <= '0;
         r_sp      <= '0;
         r_halted  <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run || step) r_state <= S_FETCH;
            end
            S_FETCH: begin
               r_instr <= r_pmem[r_pc];
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_opcode  <= r_instr[2*DW-1:DW];
               r_operand <= r_instr[DW-1:0];
               r_state   <= S_EXECUTE;
            end
            S_EXECUTE: begin
               r_res   <= r_acc;
               r_npc   <= w_pc_inc;
               r_state <= S_WRITEBACK;
               case (w_op)
                  OP_LDI:  r_res <= r_operand;
                  OP_ADDI: r_res <= r_acc + r_operand;
                  OP_SUBI: r_res <= r_acc - r_operand;
                  OP_LD,
                  OP_ST:   r_state <= S_MEMORY;
                  OP_JMP:  r_npc <= w_target;
                  OP_JZ:   if (r_acc == '0) r_npc <= w_target;
                  OP_CALL: begin
                     // Overflow halts straight from EXECUTE so acc/pc/stack stay untouched.
                     if (w_stack_full) begin
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                     end else begin
                        r_stack[r_sp] <= w_pc_inc;
                        r_sp          <= r_sp + SP_ONE;
                        r_npc         <= w_target;
                     end
                  end
                  OP_RET: begin
                     if (w_stack_empty) begin
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                     end else begin
                        r_sp  <= w_sp_dec;
                        r_npc <= r_stack[w_sp_dec];
                     end
                  end
                  OP_HALT: r_npc <= r_pc;
                  default: ;
               endcase
            end
            S_MEMORY: begin
               if (w_op == OP_LD) r_res <= r_dmem[w_daddr];
               r_state <= S_WRITEBACK;
            end
            S_WRITEBACK: begin
               r_acc <= r_res;
               r_pc  <= r_npc;
               if (w_op == OP_HALT) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else if (run) begin
                  r_state <= S_FETCH;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_HALT: r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_output          = r_acc;
   assign current_state_output = r_state;
   assign pc_output            = r_pc;
   assign opcode_bus_output    = r_opcode;
   assign operand_bus_output   = r_operand;
   assign halted               = r_halted;
   assign fault                = r_fault;

endmodule

// File: tb/tb_processor_param.sv
// tb_processor_param: table-driven arithmetic programs plus hand-written sequences for memory,
// branch, stack nesting/faults, step mode and reset during a store; results checked through a
// scoreboard queue filled when a program is started and drained when the core halts.
module tb_processor_param;

   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_SUBI = 4'h3;
   localparam logic [3:0] OP_LD   = 4'h4;
   localparam logic [3:0] OP_ST   = 4'h5;
   localparam logic [3:0] OP_JZ   = 4'h7;
   localparam logic [3:0] OP_CALL = 4'h8;
   localparam logic [3:0] OP_RET  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        step;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [31:0] prog_data;
   logic [15:0] data_output;
   logic [2:0]  current_state_output;
   logic [7:0]  pc_output;
   logic [15:0] opcode_bus_output;
   logic [15:0] operand_bus_output;
   logic        halted;
   logic        fault;

   initial forever #5 clk = ~clk;

   processor_param #(
      .DATA_WIDTH(16), .PROG_ADDR_WIDTH(8), .DMEM_ADDR_WIDTH(4), .STACK_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .data_output(data_output), .current_state_output(current_state_output),
      .pc_output(pc_output), .opcode_bus_output(opcode_bus_output),
      .operand_bus_output(operand_bus_output), .halted(halted), .fault(fault)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic [15:0] acc;
   } arith_vec_t;

   typedef struct {
      string       name;
      logic [15:0] acc;
      logic [7:0]  pc;
      logic        flt;
      int          latency;
      int          mem_cycles;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load(input logic [7:0] addr, input logic [3:0] op, input logic [15:0] opnd);
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = {12'h000, op, opnd};
      @(negedge clk);
      prog_we   = 1'b0;
   endtask

   task automatic expect_result(input string name, input logic [15:0] acc, input logic [7:0] pc,
                                input logic flt, input int lat, input int memc);
      exp_t e;
      e.name       = name;
      e.acc        = acc;
      e.pc         = pc;
      e.flt        = flt;
      e.latency    = lat;
      e.mem_cycles = memc;
      sb_q.push_back(e);
   endtask

   // Starts the program from IDLE and waits for halted. Latency is the number of edges after the
   // edge that sampled run. poke_at >= 0 attempts a program write mid-run (must be ignored).
   task automatic run_to_halt(input int budget, input bit with_step, input int poke_at);
      int   cyc;
      int   memc;
      bit   done;
      exp_t e;
      cyc  = 0;
      memc = 0;
      done = 1'b0;
      run  = 1'b1;
      step = with_step;
      while (!done && cyc < budget) begin
         if (cyc == poke_at) begin
            prog_we   = 1'b1;
            prog_addr = 8'd3;
            prog_data = {12'h000, OP_LDI, 16'h0055};
         end
         @(negedge clk);
         prog_we = 1'b0;
         step    = 1'b0;
         cyc++;
         if (current_state_output == 3'd4) memc++;
         if (halted) done = 1'b1;
      end
      run = 1'b0;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
         e = sb_q.pop_front();
         check($sformatf("%s_halt_seen", e.name), 32'(done), 32'd1);
         check($sformatf("%s_acc", e.name), 32'(data_output), 32'(e.acc));
         check($sformatf("%s_pc", e.name), 32'(pc_output), 32'(e.pc));
         check($sformatf("%s_fault", e.name), 32'(fault), 32'(e.flt));
         check($sformatf("%s_state", e.name), 32'(current_state_output), 32'd6);
         check($sformatf("%s_latency", e.name), cyc - 1, e.latency);
         check($sformatf("%s_mem_cycles", e.name), memc, e.mem_cycles);
      end
   endtask

   task automatic step_once(input string name, input logic [15:0] acc, input logic [7:0] pc);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
      check($sformatf("%s_state", name), 32'(current_state_output), 32'd0);
      check($sformatf("%s_acc", name), 32'(data_output), 32'(acc));
      check($sformatf("%s_pc", name), 32'(pc_output), 32'(pc));
      repeat (3) @(negedge clk);
      check($sformatf("%s_stays_idle", name), 32'(current_state_output), 32'd0);
      check($sformatf("%s_pc_held", name), 32'(pc_output), 32'(pc));
   endtask

   task automatic check_reset_outputs(input string name);
      check($sformatf("%s_state", name), 32'(current_state_output), 32'd0);
      check($sformatf("%s_pc", name), 32'(pc_output), 32'd0);
      check($sformatf("%s_acc", name), 32'(data_output), 32'd0);
      check($sformatf("%s_opcode", name), 32'(opcode_bus_output), 32'd0);
      check($sformatf("%s_operand", name), 32'(operand_bus_output), 32'd0);
      check($sformatf("%s_halted", name), 32'(halted), 32'd0);
      check($sformatf("%s_fault", name), 32'(fault), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arith_vec_t vecs[5];
      bit         idle_ok;
      bit         found;

      vecs[0] = '{16'd5,    16'd3,    16'd1,    16'd7};
      vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
      vecs[2] = '{16'h0000, 16'h0000, 16'h0001, 16'hFFFF};
      vecs[3] = '{16'h1234, 16'h1111, 16'h0345, 16'h2000};
      vecs[4] = '{16'h8000, 16'h8000, 16'h0001, 16'hFFFF};

      reset = 1'b1; run = 1'b0; step = 1'b0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state and quiet idling
      check_reset_outputs("reset");
      idle_ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (current_state_output != 3'd0 || pc_output != 8'd0) idle_ok = 1'b0;
      end
      check("idle_10_cycles", 32'(idle_ok), 32'd1);

      // Arithmetic table: LDI a; ADDI b; SUBI c; HALT. Row 0 also tries a mid-run program write.
      for (int i = 0; i < 5; i++) begin
         apply_reset(1);
         load(8'd0, OP_LDI,  vecs[i].a);
         load(8'd1, OP_ADDI, vecs[i].b);
         load(8'd2, OP_SUBI, vecs[i].c);
         load(8'd3, OP_HALT, 16'd0);
         expect_result($sformatf("arith%0d", i), vecs[i].acc, 8'd3, 1'b0, 16, 0);
         run_to_halt(40, 1'b0, (i == 0) ? 5 : -1);
      end

      // Wrap to zero, store/load round trip, taken JZ
      apply_reset(1);
      load(8'd0, OP_LDI,  16'hFFFF);
      load(8'd1, OP_ADDI, 16'd1);
      load(8'd2, OP_ST,   16'd2);
      load(8'd3, OP_LDI,  16'd9);
      load(8'd4, OP_LD,   16'd2);
      load(8'd5, OP_JZ,   16'd7);
      load(8'd6, OP_HALT, 16'd0);
      load(8'd7, OP_HALT, 16'd0);
      expect_result("membranch", 16'd0, 8'd7, 1'b0, 30, 2);
      run_to_halt(60, 1'b0, -1);

      // Stack nested to full depth; each return point adds a distinct value
      apply_reset(1);
      load(8'd0,  OP_LDI,  16'd0);
      load(8'd1,  OP_CALL, 16'd10);
      load(8'd2,  OP_HALT, 16'd0);
      load(8'd10, OP_ADDI, 16'h0001);
      load(8'd11, OP_CALL, 16'd20);
      load(8'd12, OP_ADDI, 16'h0010);
      load(8'd13, OP_RET,  16'd0);
      load(8'd20, OP_CALL, 16'd30);
      load(8'd21, OP_ADDI, 16'h0100);
      load(8'd22, OP_RET,  16'd0);
      load(8'd30, OP_CALL, 16'd40);
      load(8'd31, OP_ADDI, 16'h1000);
      load(8'd32, OP_RET,  16'd0);
      load(8'd40, OP_RET,  16'd0);
      expect_result("stack_nest", 16'h1111, 8'd2, 1'b0, 56, 0);
      run_to_halt(100, 1'b0, -1);

      // Program write in HALT together with reset: the write lands, registers reset
      reset     = 1'b1;
      prog_we   = 1'b1;
      prog_addr = 8'd40;
      prog_data = {12'h000, OP_CALL, 16'd50};
      @(negedge clk);
      reset   = 1'b0;
      prog_we = 1'b0;
      check_reset_outputs("halt_reset");

      // Fifth nested CALL overflows: fault, halt with pc on the CALL
      expect_result("stack_overflow", 16'h0001, 8'd40, 1'b1, 27, 0);
      run_to_halt(60, 1'b0, -1);

      // RET on an empty stack
      apply_reset(1);
      load(8'd0, OP_LDI, 16'd3);
      load(8'd1, OP_RET, 16'd0);
      expect_result("stack_underflow", 16'd3, 8'd1, 1'b1, 7, 0);
      run_to_halt(30, 1'b0, -1);

      // Step mode, then step and run together free-run to HALT
      apply_reset(1);
      load(8'd0, OP_LDI,  16'd1);
      load(8'd1, OP_ADDI, 16'd1);
      load(8'd2, OP_ADDI, 16'd1);
      load(8'd3, OP_HALT, 16'd0);
      step_once("step1", 16'd1, 8'd1);
      step_once("step2", 16'd2, 8'd2);
      expect_result("step_run", 16'd3, 8'd3, 1'b0, 8, 0);
      run_to_halt(30, 1'b1, -1);

      // Seed dmem[3], then reset during the MEMORY cycle of another ST 3
      apply_reset(1);
      load(8'd0, OP_LDI,  16'h005A);
      load(8'd1, OP_ST,   16'd3);
      load(8'd2, OP_HALT, 16'd0);
      expect_result("st_seed", 16'h005A, 8'd2, 1'b0, 13, 1);
      run_to_halt(40, 1'b0, -1);

      apply_reset(1);
      load(8'd0, OP_LDI, 16'h0077);
      run   = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (current_state_output == 3'd4) found = 1'b1;
      end
      reset = 1'b1;
      run   = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("st_reset_reached_memory", 32'(found), 32'd1);
      check_reset_outputs("st_reset");

      load(8'd0, OP_LD,   16'd3);
      load(8'd1, OP_HALT, 16'd0);
      expect_result("st_reset_dmem", 16'h005A, 8'd1, 1'b0, 9, 1);
      run_to_halt(30, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/processor_param.md
# processor_param

Parametrised successor to the fixed 16-bit multi-cycle accumulator processor. It keeps the same observation buses (state, PC, opcode, operand, data), generalised in data width, program depth, data-memory depth and call-stack depth. New over the previous core: a bench/host program-load port, run/step execution control, CALL/RET with a hardware return stack, and a sticky fault flag. It sits at the top of the processor/ hierarchy and is driven directly by its testbench.

## Interface

- DATA_WIDTH, 16: accumulator, operand, opcode-bus and data-memory word width (min 8).
- PROG_ADDR_WIDTH, 8: program memory depth is 2**PROG_ADDR_WIDTH words; PC width.
- DMEM_ADDR_WIDTH, 4: data memory depth is 2**DMEM_ADDR_WIDTH words.
- STACK_DEPTH, 4: number of return-stack entries (>=1).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- run  in  1  level; 1 = free-run.
- step  in  1  single-cycle pulse; executes one instruction from IDLE.
- prog_we  in  1  program memory write enable.
- prog_addr  in  PROG_ADDR_WIDTH  program write address.
- prog_data  in  2*DATA_WIDTH  instruction word {opcode, operand}.
- data_output  out  DATA_WIDTH  accumulator.
- current_state_output  out  3  FSM state code.
- pc_output  out  PROG_ADDR_WIDTH  program counter.
- opcode_bus_output  out  DATA_WIDTH  latched opcode field.
- operand_bus_output  out  DATA_WIDTH  latched operand field.
- halted  out  1  1 in HALT state.
- fault  out  1  sticky; stack overflow/underflow.

## Operation

- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Code 7 is unreachable and returns to IDLE.
- IDLE: if run=1 or step=1, go to FETCH. The instruction completes at WRITEBACK. From WRITEBACK, go to FETCH if run=1, else IDLE. A step-initiated instruction returns to IDLE unless run=1.
- FETCH: read pmem[pc]. DECODE: latch opcode/operand buses. EXECUTE: ALU, branch and stack. MEMORY: LD/ST only. WRITEBACK: update acc and pc.
- Opcodes (low 4 bits of opcode field; all other values are NOP):
  - 0 NOP.
  - 1 LDI: acc=operand.
  - 2 ADDI: acc+=operand.
  - 3 SUBI: acc-=operand.
  - 4 LD: acc=dmem[operand].
  - 5 ST: dmem[operand]=acc.
  - 6 JMP: pc=operand.
  - 7 JZ: pc=operand if acc==0.
  - 8 CALL: push pc+1, pc=operand.
  - 9 RET: pc=pop.
  - F HALT.
- Arithmetic is modulo 2**DATA_WIDTH with no carry flag. Addresses use the low bits of the operand. pc+1 wraps modulo 2**PROG_ADDR_WIDTH.
- HALT opcode: at WRITEBACK, enter HALT with pc unchanged. HALT is left only by reset.
- CALL with the stack full, or RET with it empty: fault=1, enter HALT, acc/pc/stack unchanged.
- prog_we is honoured only in IDLE or HALT; it is ignored in other states. Program memory is not cleared by reset. Data memory is not cleared by reset.
- Reset values:
  - state=IDLE, pc=0, acc=0.
  - opcode/operand buses=0.
  - stack pointer=0 (empty).
  - halted=0, fault=0.

## Timing

- All outputs are registered.
- current_state_output changes on the edge after the condition is sampled.
- Latency: 4 cycles per instruction (FETCH..WRITEBACK with EXECUTE→WRITEBACK direct). LD/ST take 5 cycles (via MEMORY).
- run=1 in IDLE at edge N gives FETCH from N+1. The first instruction's acc/pc update is visible after edge N+4.
- run dropped mid-instruction: the instruction completes, then IDLE. Nothing is aborted.
- run and step both high: treated as run.
- step held over several cycles only starts one instruction per IDLE visit.
- prog_we in HALT with a simultaneous reset: the write still occurs; reset wins for all registers.
- Reset asserted mid-instruction: all registers take reset values at that edge. A partially executed ST does not write.
- halted is asserted in the same cycle current_state_output=6.

## Test plan

- Reset/idle: reset 2 cycles, run=0 → state=0, pc=0, data_output=0, halted=0, fault=0. No state change for 10 cycles.
- Arithmetic and HALT: load LDI 5, ADDI 3, SUBI 1, HALT; pulse run → data_output=7, pc=3, halted=1 after 16 cycles. A prog_we during execution has no effect.
- Memory, branch and wrap: load LDI 0xFFFF, ADDI 1, ST 2, LD 2, JZ 7, …, HALT at 7 → acc=0 and pc=7. Check the 5-cycle LD/ST timing.
- Stack: CALL/RET nesting of depth STACK_DEPTH returns to the correct PCs. One more CALL → fault=1, halted=1, pc stays at the CALL. RET on an empty stack → fault=1.
- Step mode: run=0, step pulses → exactly one instruction per pulse, state returns to 0. Pulse step+run together → free-runs.
- Reset mid-ST: assert reset during MEMORY of ST 3 → dmem[3] unchanged, all outputs at reset values the next cycle.
